// File: rtl/ps2_device_stimulus.sv
// PS/2 keyboard device model: queues scancode bytes and serialises them as 11-bit PS/2 frames.
// Latency: first start bit 1 cycle after IDLE sees a non-empty FIFO; frame = 22*CLK_DIV cycles.
// Backpressure: in_ready drops when the FIFO is full; host_inhibit aborts/blocks transmission.
// Optional build macro: PS2_STIM_PARITY_ERR_EN adds in_parity_err to force a bad parity bit.
module ps2_device_stimulus #(
  parameter int CLK_DIV    = 2500,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 5000,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
`ifdef PS2_STIM_PARITY_ERR_EN
  input  logic                          in_parity_err,
`endif
  input  logic                          host_inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_dat,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              frames_sent
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;
  localparam int DIV_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TW      = $clog2(DIV_MAX + 1);
`ifdef PS2_STIM_PARITY_ERR_EN
  localparam int FW      = 9;
`else
  localparam int FW      = 8;
`endif

  localparam logic [TW-1:0] HALF_LD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_IDX = 4'd10;

  typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, GAP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [3:0]      idx;

  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [FW-1:0]   wr_word;
  logic [FW-1:0]   head;
  logic            push;
  logic            pop;
  logic            parity;
  logic [10:0]     frame;
  logic            timer_zero;

`ifdef PS2_STIM_PARITY_ERR_EN
  assign wr_word = {in_parity_err, in_data};
`else
  assign wr_word = in_data;
`endif

  assign in_ready   = (count != FULL_CNT);
  assign fifo_count = count;
  assign push       = in_valid && in_ready;
  assign timer_zero = (timer == '0);
  // The head byte stays queued until its stop bit completes, so an aborted frame can resend it.
  assign pop        = (state == BIT_LOW) && timer_zero && (idx == LAST_IDX) && !host_inhibit;
  assign head       = mem[rd_ptr];

`ifdef PS2_STIM_PARITY_ERR_EN
  assign parity = (~^head[7:0]) ^ head[8];
`else
  assign parity = ~^head[7:0];
`endif

  // Frame bit order: start, data LSB first, odd parity, stop.
  assign frame = {1'b1, parity, head[7:0], 1'b0};

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: inhibit during a bit aborts straight into GAP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count != '0 && !host_inhibit) state_nxt = BIT_HIGH;
      end
      BIT_HIGH: begin
        if (host_inhibit)    state_nxt = GAP;
        else if (timer_zero) state_nxt = BIT_LOW;
      end
      BIT_LOW: begin
        if (host_inhibit)    state_nxt = GAP;
        else if (timer_zero) state_nxt = (idx == LAST_IDX) ? GAP : BIT_HIGH;
      end
      GAP: begin
        if (timer_zero) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Down-counter reloaded on every state entry; bit index restarts at each new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
      idx   <= '0;
    end else begin
      if (state_nxt != state) begin
        case (state_nxt)
          BIT_HIGH, BIT_LOW: timer <= HALF_LD;
          GAP:               timer <= GAP_LD;
          default:           timer <= '0;
        endcase
      end else if (!timer_zero) begin
        timer <= timer - 1'b1;
      end
      if (state == IDLE && state_nxt == BIT_HIGH) begin
        idx <= '0;
      end else if (state == BIT_LOW && state_nxt == BIT_HIGH) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Completion pulse and frame counter move together on the pop edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_done     <= 1'b0;
      frames_sent <= '0;
    end else begin
      tx_done <= pop;
      if (pop) frames_sent <= frames_sent + CNT_W'(1);
    end
  end

  // FSM outputs: data only changes with the clock high; both lines idle high outside a bit
  always_comb begin
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    busy    = (state != IDLE);
    case (state)
      BIT_HIGH: ps2_dat = frame[idx];
      BIT_LOW: begin
        ps2_clk = 1'b0;
        ps2_dat = frame[idx];
      end
      default: begin
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
      end
    endcase
  end

endmodule
